enet_txarb: RTL and testbench
=============================

Name: enet_txarb

Overview:
- Two-source transmit packet scheduler in front of the hardware-MAC insertion stage in the Ethernet TX path.
- Grants one requester at a time, round-robin on ties, and muxes the granted byte stream onto a single i_ce-paced valid/byte stream.
- Drives the per-packet MAC-insertion enable; enforces a drain-plus-inter-packet-gap before the next grant; aborts a grant if the source never starts.

Parameters:
- IPG_CYCLES, 12, i_ce cycles of idle inserted after downstream goes idle; legal range 1..255.
- START_TIMEOUT, 64, i_ce cycles a granted source may take to raise its valid; legal range 2..255.
- SRC0_ADDMAC, 1'b1, o_en value driven while source 0 owns the stream.
- SRC1_ADDMAC, 1'b1, o_en value driven while source 1 owns the stream.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  byte-rate clock enable; all state advances only when high.
- i_req0  in  1  source 0 has a packet pending.
- o_gnt0  out  1  source 0 owns the stream.
- i_v0  in  1  source 0 byte valid.
- i_byte0  in  8  source 0 byte.
- i_req1  in  1  source 1 has a packet pending.
- o_gnt1  out  1  source 1 owns the stream.
- i_v1  in  1  source 1 byte valid.
- i_byte1  in  8  source 1 byte.
- i_tx_busy  in  1  downstream (MAC inserter output) still valid.
- o_v  out  1  merged stream valid.
- o_byte  out  8  merged stream byte.
- o_en  out  1  MAC-insertion enable to the downstream stage.
- o_src  out  1  index of the current or last owner.
- o_err  out  1  one-clock pulse on start timeout.

Behaviour:
- Reset: on i_reset (synchronous, active-high, one clock), all state is cleared regardless of i_ce.
  - o_v=0, o_byte=8'h00, o_gnt0=o_gnt1=0, o_en=0, o_src=0, o_err=0.
  - State=IDLE; round-robin last-owner register=1, so source 0 wins the first tie.
  - Reset mid-packet truncates the packet: o_v drops on the next clock and no error is flagged.
- i_ce low: state, counters, o_v, o_byte, grants and o_en are held. o_err still self-clears after one clock.
- State IDLE, on each i_ce:
  - Neither request high: stay in IDLE.
  - One request high: grant that source.
  - Both requests high: grant the source that is not the last owner.
  - On a grant: o_gntN<=1, o_src<=N, o_en<=SRCN_ADDMAC, start timer cleared, go to GRANT.
- State GRANT, on each i_ce:
  - Granted i_vN high: go to SEND; o_v<=1, o_byte<=i_byteN on the same edge.
  - Granted i_reqN low with i_vN low: o_gntN<=0, return to IDLE; last owner unchanged, no error.
  - Timer reaches START_TIMEOUT-1: o_gntN<=0, o_err pulses for 1 clock, last owner<=N, go to GAP with the gap counter cleared (DRAIN skipped).
  - Otherwise: increment the timer.
- State SEND, on each i_ce:
  - o_v<=i_vN, o_byte<=i_byteN. Latency is one clock; bytes are never dropped, duplicated or reordered.
  - When i_vN goes low: o_v<=0, o_byte<=8'h00, o_gntN<=0, last owner<=N, go to DRAIN.
  - A packet is one contiguous valid run. The non-granted source's valid and byte are ignored in all states.
- State DRAIN: on the first i_ce with i_tx_busy low, go to GAP with the gap counter cleared.
- State GAP:
  - Count i_ce cycles; on count==IPG_CYCLES-1, go to IDLE.
  - Requests arriving during DRAIN or GAP are held pending and serviced from IDLE.
- o_en and o_src hold from the grant through DRAIN and GAP until the next grant, so they are stable for the whole downstream packet.
- Grant signals: o_gnt0 and o_gnt1 are never both high. A grant is never high outside GRANT or SEND.
- Counter widths: counters are 8 bits and saturate, never wrap.

Test Plan:
- Single packet: reset, then i_req0=1 and 5-byte run 0x11..0x15 on i_v0 one ce after grant, i_tx_busy low. Required: o_v high exactly 5 ce cycles, bytes 0x11..0x15, o_en=1, o_src=0, o_gnt0 falls on the same edge as o_v falls. Next grant no earlier than 12 ce cycles after o_v falls.
- Tie, round-robin: i_req0 and i_req1 held high, each sending 3-byte packets. Required: grant order 0,1,0,1; never both grants high; with i_tx_busy held high 4 ce cycles past o_v, the IPG count starts only after busy drops.
- Timeout: i_req1=1, i_v1 held low. Required: o_gnt1 high for 64 ce cycles; o_err one-clock pulse; o_gnt1 low; source 0 requesting afterward gets the next grant after the 12-cycle gap.
- Ce throttling: i_ce high on alternate clocks during a 6-byte packet from source 1 with SRC1_ADDMAC=0. Required: o_byte and o_v change only on ce edges; o_en=0 throughout; byte sequence intact.
- Reset mid-packet: assert i_reset on the 3rd byte. Required: o_v=0, grants=0, o_err=0 next clock; with both requests high afterward, source 0 is granted first.
- Request withdrawal: i_req0 drops while in GRANT before any valid. Required: o_gnt0 drops, no o_err, return to IDLE with no gap; a pending i_req1 is granted on the next ce.

Source files
------------

// File: rtl/enet_txarb.sv
// Two-source Ethernet TX scheduler: round-robin grant, byte-stream mux, MAC-insertion enable,
// drain plus inter-packet gap before the next grant, and abort of a grant whose source never starts.
module enet_txarb #(
  parameter int   IPG_CYCLES    = 12,
  parameter int   START_TIMEOUT = 64,
  parameter logic SRC0_ADDMAC   = 1'b1,
  parameter logic SRC1_ADDMAC   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_req0,
  output logic       o_gnt0,
  input  logic       i_v0,
  input  logic [7:0] i_byte0,
  input  logic       i_req1,
  output logic       o_gnt1,
  input  logic       i_v1,
  input  logic [7:0] i_byte1,
  input  logic       i_tx_busy,
  output logic       o_v,
  output logic [7:0] o_byte,
  output logic       o_en,
  output logic       o_src,
  output logic       o_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] IPG_LAST = 8'(IPG_CYCLES - 1);

  logic [2:0] state;
  logic       last_owner;
  logic [7:0] start_tmr;
  logic [7:0] gap_cnt;
  logic       own_req;
  logic       own_v;
  logic [7:0] own_byte;
  logic       pick;

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  always_comb begin
    own_req  = o_src ? i_req1  : i_req0;
    own_v    = o_src ? i_v1    : i_v0;
    own_byte = o_src ? i_byte1 : i_byte0;
    // On a tie the source that did not own the stream last wins.
    pick     = (i_req0 && i_req1) ? ~last_owner : i_req1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      start_tmr  <= 8'h00;
      gap_cnt    <= 8'h00;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_v        <= 1'b0;
      o_byte     <= 8'h00;
      o_en       <= 1'b0;
      o_src      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (i_ce) begin
        case (state)
          ST_IDLE: begin
            if (i_req0 || i_req1) begin
              o_gnt0    <= ~pick;
              o_gnt1    <= pick;
              o_src     <= pick;
              o_en      <= pick ? SRC1_ADDMAC : SRC0_ADDMAC;
              start_tmr <= 8'h00;
              state     <= ST_GRANT;
            end
          end
          ST_GRANT: begin
            if (own_v) begin
              o_v    <= 1'b1;
              o_byte <= own_byte;
              state  <= ST_SEND;
            end else if (!own_req) begin
              o_gnt0 <= 1'b0;
              o_gnt1 <= 1'b0;
              state  <= ST_IDLE;
            end else if (start_tmr == TMO_LAST) begin
              // Source never started: release it and still pay the gap, but no drain.
              o_gnt0     <= 1'b0;
              o_gnt1     <= 1'b0;
              o_err      <= 1'b1;
              last_owner <= o_src;
              gap_cnt    <= 8'h00;
              state      <= ST_GAP;
            end else begin
              start_tmr <= sat_inc8(start_tmr);
            end
          end
          ST_SEND: begin
            if (own_v) begin
              o_v    <= 1'b1;
              o_byte <= own_byte;
            end else begin
              o_v        <= 1'b0;
              o_byte     <= 8'h00;
              o_gnt0     <= 1'b0;
              o_gnt1     <= 1'b0;
              last_owner <= o_src;
              state      <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (!i_tx_busy) begin
              gap_cnt <= 8'h00;
              state   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_cnt == IPG_LAST) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= sat_inc8(gap_cnt);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enet_txarb.sv
// Bench for enet_txarb: directed scenarios plus randomized traffic, all checked every clock
// against a packet-level reference model of the scheduler.
`timescale 1ns/1ps
module tb_enet_txarb;

  localparam int   IPG = 12;
  localparam int   TMO = 64;
  localparam logic AM0 = 1'b1;
  localparam logic AM1 = 1'b0;

  logic       i_clk = 1'b0;
  logic       i_reset, i_ce, i_tx_busy;
  logic       i_req0, i_v0, i_req1, i_v1;
  logic [7:0] i_byte0, i_byte1;
  logic       o_gnt0, o_gnt1, o_v, o_en, o_src, o_err;
  logic [7:0] o_byte;

  enet_txarb #(
    .IPG_CYCLES(IPG), .START_TIMEOUT(TMO), .SRC0_ADDMAC(AM0), .SRC1_ADDMAC(AM1)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce),
    .i_req0(i_req0), .o_gnt0(o_gnt0), .i_v0(i_v0), .i_byte0(i_byte0),
    .i_req1(i_req1), .o_gnt1(o_gnt1), .i_v1(i_v1), .i_byte1(i_byte1),
    .i_tx_busy(i_tx_busy), .o_v(o_v), .o_byte(o_byte), .o_en(o_en),
    .o_src(o_src), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Values seen just before the active edge.
  logic       p_rst, p_ce, p_busy;
  logic [1:0] p_req, p_v, p_gnt;
  logic [7:0] p_b [2];

  // Reference model: who owns the stream and what must be blocked before the next grant.
  bit         m_act = 0, m_own = 0, m_start = 0, m_last = 1, m_drain = 0;
  bit         m_src = 0, m_en = 0, m_err = 0, m_v = 0;
  logic [7:0] m_b = 8'h00;
  int         m_wait = 0, m_gap = 0;

  // Source behaviour: each source holds a packet, starts it some ce cycles after its grant.
  logic [7:0] pkt [2][16];
  int         plen [2], pidx [2], pdly [2], npk [2];
  bit         armed [2];
  bit         junk = 0;
  int         done_cnt = 0;
  int         gnt_log [$];

  task automatic model_step();
    int s;
    m_err = 0;
    if (p_rst) begin
      m_act = 0; m_own = 0; m_last = 1; m_drain = 0; m_gap = 0;
      m_src = 0; m_en = 0; m_v = 0; m_b = 8'h00;
    end else if (p_ce) begin
      if (m_act) begin
        s = int'(m_own);
        if (p_v[s]) begin
          m_start = 1; m_v = 1; m_b = p_b[s];
        end else if (m_start) begin
          m_act = 0; m_v = 0; m_b = 8'h00; m_last = m_own; m_drain = 1;
        end else if (!p_req[s]) begin
          m_act = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_act = 0; m_err = 1; m_last = m_own; m_gap = IPG;
          end
        end
      end else if (m_drain) begin
        if (!p_busy) begin
          m_drain = 0; m_gap = IPG;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (p_req != 2'b00) begin
        m_own = (p_req == 2'b11) ? !m_last : p_req[1];
        m_act = 1; m_start = 0; m_wait = 0;
        m_src = m_own; m_en = m_own ? AM1 : AM0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("o_v", o_v, m_v);
    check_eq("o_byte", o_byte, m_b);
    check_eq("o_gnt0", o_gnt0, m_act && !m_own);
    check_eq("o_gnt1", o_gnt1, m_act && m_own);
    check_eq("o_src", o_src, m_src);
    check_eq("o_en", o_en, m_en);
    check_eq("o_err", o_err, m_err);
    check_eq("gnt_excl", o_gnt0 & o_gnt1, 1'b0);
  endtask

  task automatic new_pkt(input int s, input int len, input int dly);
    for (int i = 0; i < len; i++) pkt[s][i] = 8'($urandom);
    plen[s] = len; pidx[s] = 0; pdly[s] = dly; armed[s] = 0;
  endtask

  task automatic apply_drive();
    logic       g [2];
    logic       v;
    logic [7:0] b;
    g[0] = o_gnt0; g[1] = o_gnt1;
    for (int s = 0; s < 2; s++) begin
      v = armed[s] && (pdly[s] == 0) && (pidx[s] < plen[s]);
      b = v ? pkt[s][pidx[s]] : 8'($urandom);
      if (!v && junk && !g[s]) v = 1'($urandom_range(0, 1));
      if (s == 0) begin
        i_req0 = (plen[0] > 0); i_v0 = v; i_byte0 = b;
      end else begin
        i_req1 = (plen[1] > 0); i_v1 = v; i_byte1 = b;
      end
    end
  endtask

  task automatic drive_sources();
    logic g [2];
    g[0] = o_gnt0; g[1] = o_gnt1;
    for (int s = 0; s < 2; s++) begin
      if (p_rst) begin
        plen[s] = 0; pidx[s] = 0; armed[s] = 0; npk[s] = 0;
      end else begin
        if (p_ce && p_gnt[s] && p_v[s]) pidx[s]++;
        else if (p_ce && p_gnt[s] && armed[s] && pdly[s] > 0) pdly[s]--;
        if (!p_gnt[s] && g[s]) armed[s] = 1;
        if (p_gnt[s] && !g[s] && pidx[s] == 0) armed[s] = 0;
        if (armed[s] && plen[s] > 0 && pidx[s] >= plen[s]) begin
          armed[s] = 0; plen[s] = 0; pidx[s] = 0; done_cnt++;
          if (npk[s] > 0) begin
            npk[s]--;
            new_pkt(s, $urandom_range(1, 8), $urandom_range(0, 5));
          end
        end
      end
    end
    apply_drive();
  endtask

  task automatic tick();
    p_rst = i_reset; p_ce = i_ce; p_busy = i_tx_busy;
    p_req = {i_req1, i_req0}; p_v = {i_v1, i_v0}; p_gnt = {o_gnt1, o_gnt0};
    p_b[0] = i_byte0; p_b[1] = i_byte1;
    @(posedge i_clk);
    #1;
    if (!p_gnt[0] && o_gnt0) gnt_log.push_back(0);
    if (!p_gnt[1] && o_gnt1) gnt_log.push_back(1);
    model_step();
    compare_outputs();
    drive_sources();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    gnt_log.delete();
  endtask

  initial begin
    int         nv, ng1, ne, bcnt, nb;
    logic [7:0] got_b [16];
    logic [7:0] exp_b [16];

    i_reset = 1'b1; i_ce = 1'b0; i_tx_busy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      plen[s] = 0; pidx[s] = 0; pdly[s] = 0; npk[s] = 0; armed[s] = 0;
    end
    apply_drive();
    tick();
    tick();
    check_eq("rst_v", o_v, 1'b0);
    check_eq("rst_byte", o_byte, 8'h00);
    check_eq("rst_gnt", {o_gnt1, o_gnt0}, 2'b00);
    check_eq("rst_en_src_err", {o_en, o_src, o_err}, 3'b000);
    i_reset = 1'b0; i_ce = 1'b1;

    // Single 5-byte packet from source 0.
    for (int i = 0; i < 5; i++) pkt[0][i] = 8'h11 + 8'(i);
    plen[0] = 5; pidx[0] = 0; pdly[0] = 0; armed[0] = 0;
    apply_drive();
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_v) begin
        if (nv < 16) got_b[nv] = o_byte;
        nv++;
      end
    end
    check_eq("sp_len", nv, 5);
    for (int i = 0; i < 5; i++) check_eq("sp_byte", got_b[i], 8'h11 + 8'(i));

    // Tie: both sources always pending, busy lingers past each packet.
    do_reset();
    new_pkt(0, 3, 0); npk[0] = 1;
    new_pkt(1, 3, 0); npk[1] = 1;
    apply_drive();
    bcnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (o_v) bcnt = 5;
      else if (bcnt > 0) bcnt--;
      i_tx_busy = (bcnt > 0);
    end
    i_tx_busy = 1'b0;
    check_eq("tie_n", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) check_eq("tie_order", gnt_log[i], i % 2);

    // Start timeout on a mute source 1, then source 0 asks.
    do_reset();
    new_pkt(1, 3, 1000);
    apply_drive();
    ng1 = 0; ne = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (o_gnt1) ng1++;
      if (o_err) ne++;
    end
    check_eq("tmo_gnt_len", ng1, TMO);
    check_eq("tmo_err_cnt", ne, 1);
    new_pkt(0, 2, 0);
    apply_drive();
    for (int c = 0; c < 20; c++) tick();
    check_eq("tmo_n", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) check_eq("tmo_next", gnt_log[1], 0);
    plen[1] = 0; armed[1] = 0;
    apply_drive();
    for (int c = 0; c < 30; c++) tick();

    // Ce on alternate clocks, 6 bytes from source 1 (no MAC insertion).
    do_reset();
    new_pkt(1, 6, 0);
    for (int i = 0; i < 6; i++) exp_b[i] = pkt[1][i];
    apply_drive();
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      i_ce = ~i_ce;
      tick();
      if (p_ce && o_v) begin
        if (nb < 16) got_b[nb] = o_byte;
        nb++;
      end
    end
    i_ce = 1'b1;
    check_eq("thr_len", nb, 6);
    for (int i = 0; i < 6; i++) check_eq("thr_byte", got_b[i], exp_b[i]);

    // Reset while the third byte is on the output.
    do_reset();
    new_pkt(0, 6, 0);
    apply_drive();
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      tick();
      if (o_v) nb++;
    end
    check_eq("rmp_reached", nb, 3);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("rmp_v", o_v, 1'b0);
    check_eq("rmp_gnt", {o_gnt1, o_gnt0}, 2'b00);
    check_eq("rmp_err", o_err, 1'b0);
    gnt_log.delete();
    new_pkt(0, 2, 0);
    new_pkt(1, 2, 0);
    apply_drive();
    for (int c = 0; c < 10; c++) tick();
    check_eq("rmp_first_n", gnt_log.size() > 0, 1'b1);
    if (gnt_log.size() > 0) check_eq("rmp_first", gnt_log[0], 0);
    for (int c = 0; c < 50; c++) tick();

    // Source 0 withdraws before starting; pending source 1 follows with no gap.
    do_reset();
    new_pkt(0, 2, 1000);
    new_pkt(1, 2, 0);
    apply_drive();
    for (int c = 0; c < 4; c++) tick();
    check_eq("wd_gnt0_on", o_gnt0, 1'b1);
    plen[0] = 0; armed[0] = 0;
    apply_drive();
    tick();
    check_eq("wd_gnt0_off", o_gnt0, 1'b0);
    check_eq("wd_err", o_err, 1'b0);
    tick();
    check_eq("wd_gnt1", o_gnt1, 1'b1);
    for (int c = 0; c < 40; c++) tick();

    // Randomized traffic: random ce, busy, lengths, start delays, junk on idle sources.
    do_reset();
    done_cnt = 0; junk = 1;
    new_pkt(0, $urandom_range(1, 8), $urandom_range(0, 5)); npk[0] = 14;
    new_pkt(1, $urandom_range(1, 8), $urandom_range(0, 5)); npk[1] = 14;
    apply_drive();
    for (int c = 0; c < 6000 && done_cnt < 30; c++) begin
      i_ce = ($urandom_range(0, 3) != 0);
      i_tx_busy = ($urandom_range(0, 4) == 0);
      tick();
    end
    check_eq("rnd_done", done_cnt, 30);
    junk = 0; i_ce = 1'b1; i_tx_busy = 1'b0;
    apply_drive();
    for (int c = 0; c < 40; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
